operand_stage: RTL and testbench

Operand-fetch stage that sits directly upstream of the 16-bit `ALU` and drives its `ALUSelect`, `data1` and `data2` inputs from a registered output. It holds the 8 x 16 general register file and selects operands from it, the immediate, or write-back bypass. A per-register pending scoreboard stalls the issue of any instruction whose source or destination register still has a result in flight. A valid/ready handshake on both sides lets the decoder and the downstream execute path apply back-pressure.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/reg_file.sv | 23 ++
 rtl/operand_stage.sv | 83 ++++++++
 tb/tb_operand_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath widths, ALU select codes and operand-stage types shared across the CPU.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int SEL_W = 4;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [SEL_W-1:0] ALU_AND = 4'd2;
  localparam logic [SEL_W-1:0] ALU_OR = 4'd3;
  localparam logic [SEL_W-1:0] ALU_XOR = 4'd4;
  localparam logic [SEL_W-1:0] ALU_NOT = 4'd5;
  localparam logic [SEL_W-1:0] ALU_PASS_B = 4'd6;
  localparam logic [SEL_W-1:0] ALU_SHL = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SHR = 4'd8;
  typedef enum logic {ST_EMPTY, ST_FULL} stage_state_e;
  // One-hot of a register index; r0 never has a scoreboard bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] a, input logic en);
    return (en && a != '0) ? NUM_REGS'(1) << a : '0;
  endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 8 x 16 general registers, two async read ports, one sync write port, r0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0]     rdata1_o,
  output logic [DATA_W-1:0]     rdata2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (we_i && waddr_i != '0)
      regs_q[waddr_i] <= wdata_i;
  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/operand_stage.sv
// operand_stage: operand fetch with write-back bypass, pending scoreboard and a registered
// valid/ready output feeding the ALU.
module operand_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_alu_sel,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic                  in_use_imm,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      ALUSelect,
  output logic [DATA_W-1:0]     data1,
  output logic [DATA_W-1:0]     data2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en
);
  stage_state_e state_q, state_d;
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [SEL_W-1:0] sel_q;
  logic [DATA_W-1:0] d1_q, d2_q, rf_d1, rf_d2, op1, op2;
  logic [REG_ADDR_W-1:0] rd_q;
  logic wr_q, hit1, hit2, hitd, hazard, accept;
  reg_file u_rf (
    .clk(clk), .rst_n(rst_n),
    .raddr1_i(in_rs1), .raddr2_i(in_rs2),
    .rdata1_o(rf_d1), .rdata2_o(rf_d2),
    .we_i(wb_en), .waddr_i(wb_addr), .wdata_i(wb_data)
  );
  // A register being written back this cycle is both bypassed and no longer a hazard.
  always_comb begin
    hit1 = wb_en && wb_addr == in_rs1 && in_rs1 != '0;
    hit2 = wb_en && wb_addr == in_rs2 && in_rs2 != '0;
    hitd = wb_en && wb_addr == in_rd && in_rd != '0;
    op1 = hit1 ? wb_data : rf_d1;
    op2 = in_use_imm ? in_imm : hit2 ? wb_data : rf_d2;
    hazard = (pend_q[in_rs1] && !hit1) || (!in_use_imm && pend_q[in_rs2] && !hit2) ||
             (in_wr_en && pend_q[in_rd] && !hitd);
    in_ready = (state_q == ST_EMPTY || out_ready) && !hazard;
    accept = in_valid && in_ready;
    pend_d = (pend_q & ~reg_mask(wb_addr, wb_en)) | reg_mask(in_rd, accept && in_wr_en);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_EMPTY;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == ST_EMPTY) ? (accept ? ST_FULL : ST_EMPTY)
                                    : ((out_ready && !accept) ? ST_EMPTY : ST_FULL);
  always_comb out_valid = state_q == ST_FULL;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_q <= '0;
      sel_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      rd_q <= '0;
      wr_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        sel_q <= in_alu_sel;
        d1_q <= op1;
        d2_q <= op2;
        rd_q <= in_rd;
        wr_q <= in_wr_en;
      end
    end
  assign ALUSelect = sel_q;
  assign data1 = d1_q;
  assign data2 = d2_q;
  assign out_rd = rd_q;
  assign out_wr_en = wr_q;
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed vector table plus hand-written stall, back-pressure and reset sequences.
module tb_operand_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid, in_ready, in_wr_en, in_use_imm, wb_en, out_valid, out_ready, out_wr_en;
  logic [3:0] in_alu_sel, ALUSelect;
  logic [2:0] in_rs1, in_rs2, in_rd, wb_addr, out_rd;
  logic [15:0] in_imm, wb_data, data1, data2;
  int n_chk = 0, n_pass = 0;

  operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_sel(in_alu_sel), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALUSelect(ALUSelect),
    .data1(data1), .data2(data2), .out_rd(out_rd), .out_wr_en(out_wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel; logic [2:0] rs1, rs2; logic use_imm; logic [15:0] imm;
    logic wb_en; logic [2:0] wb_addr; logic [15:0] wb_data; logic [15:0] e1, e2;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_wr_en = 0; in_use_imm = 0; in_imm = '0; in_alu_sel = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; wb_en = 0; wb_addr = '0; wb_data = '0; out_ready = 1;
  endtask

  task automatic issue(input logic [3:0] sel, input logic [2:0] rs1, rs2, rd, input logic wr);
    in_valid = 1; in_alu_sel = sel; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_wr_en = wr;
    in_use_imm = 0;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    logic [15:0] init_vals [8];
    init_vals = '{16'h0, 16'd5, 16'd1, 16'h0300, 16'h0404, 16'h5005, 16'hFFFF, 16'h8000};
    vecs[0] = '{4'd0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 16'd5, 16'd1};
    vecs[1] = '{4'd6, 3'd0, 3'd0, 1'b1, 16'h00FF, 1'b0, 3'd0, 16'h0, 16'h0, 16'h00FF};
    vecs[2] = '{4'd3, 3'd7, 3'd6, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h8000, 16'hFFFF};
    vecs[3] = '{4'd15, 3'd5, 3'd0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h5005, 16'h0};
    vecs[4] = '{4'd9, 3'd3, 3'd4, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0, 16'h0300, 16'h1234};
    vecs[5] = '{4'd2, 3'd4, 3'd4, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0404, 16'h0404};
    vecs[6] = '{4'd4, 3'd5, 3'd5, 1'b0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[7] = '{4'd1, 3'd5, 3'd2, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 16'hBEEF, 16'd1};
    vecs[8] = '{4'd8, 3'd0, 3'd0, 1'b0, 16'h0, 1'b1, 3'd0, 16'h7777, 16'h0, 16'h0};
    idle();
    step();
    step();
    chk("rst out_valid", out_valid, 0);
    chk("rst ALUSelect", ALUSelect, 0);
    chk("rst data1", data1, 0);
    chk("rst data2", data2, 0);
    chk("rst out_rd", out_rd, 0);
    chk("rst out_wr_en", out_wr_en, 0);
    rst_n = 1;
    #1 chk("rst in_ready", in_ready, 1);
    for (int r = 1; r < 8; r++) begin
      wb(3'(r), init_vals[r]);
      step();
    end
    idle();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1; in_alu_sel = vecs[i].sel; in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      in_use_imm = vecs[i].use_imm; in_imm = vecs[i].imm;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      #1 chk($sformatf("vec%0d in_ready", i), in_ready, 1);
      step();
      chk($sformatf("vec%0d out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d ALUSelect", i), ALUSelect, vecs[i].sel);
      chk($sformatf("vec%0d data1", i), data1, vecs[i].e1);
      chk($sformatf("vec%0d data2", i), data2, vecs[i].e2);
    end
    idle();
    issue(4'd0, 3'd1, 3'd2, 3'd3, 1);
    #1 chk("raw issue ready", in_ready, 1);
    step();
    chk("raw issue out_rd", out_rd, 3);
    chk("raw issue out_wr_en", out_wr_en, 1);
    issue(4'd2, 3'd3, 3'd0, 3'd0, 0);
    #1 chk("raw stall0", in_ready, 0);
    step();
    chk("raw drained", out_valid, 0);
    #1 chk("raw stall1", in_ready, 0);
    wb(3'd3, 16'hABCD);
    #1 chk("raw wb ready", in_ready, 1);
    step();
    chk("raw out_valid", out_valid, 1);
    chk("raw bypass data1", data1, 16'hABCD);
    idle();
    issue(4'd0, 3'd1, 3'd0, 3'd5, 1);
    step();
    issue(4'd1, 3'd1, 3'd0, 3'd5, 1);
    in_use_imm = 1;
    #1 chk("waw stall", in_ready, 0);
    wb(3'd5, 16'h1111);
    #1 chk("waw wb ready", in_ready, 1);
    step();
    chk("waw ALUSelect", ALUSelect, 1);
    chk("waw out_rd", out_rd, 5);
    idle();
    in_rs1 = 3'd1; in_rs2 = 3'd5; in_use_imm = 1;
    #1 chk("imm ignores rs2 pend", in_ready, 1);
    in_use_imm = 0;
    #1 chk("rs2 pend stall", in_ready, 0);
    wb(3'd5, 16'h2222);
    step();
    idle();
    step();
    out_ready = 0;
    issue(4'd5, 3'd1, 3'd2, 3'd0, 0);
    step();
    chk("bp out_valid", out_valid, 1);
    chk("bp data1", data1, 16'd5);
    issue(4'd1, 3'd7, 3'd6, 3'd0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp%0d in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d hold sel", k), ALUSelect, 5);
      chk($sformatf("bp%0d hold data1", k), data1, 16'd5);
      chk($sformatf("bp%0d hold data2", k), data2, 16'd1);
      chk($sformatf("bp%0d hold valid", k), out_valid, 1);
      step();
    end
    out_ready = 1;
    #1 chk("bp release ready", in_ready, 1);
    step();
    chk("bp next sel", ALUSelect, 1);
    chk("bp next data1", data1, 16'h8000);
    chk("bp next data2", data2, 16'hFFFF);
    idle();
    step();
    chk("drain out_valid", out_valid, 0);
    chk("drain keeps data1", data1, 16'h8000);
    issue(4'd0, 3'd1, 3'd2, 3'd4, 1);
    wb(3'd4, 16'h4444);
    #1 chk("setclr ready", in_ready, 1);
    step();
    idle();
    issue(4'd3, 3'd4, 3'd0, 3'd0, 0);
    #1 chk("setclr stall0", in_ready, 0);
    step();
    #1 chk("setclr stall1", in_ready, 0);
    wb(3'd4, 16'h4545);
    #1 chk("setclr wb ready", in_ready, 1);
    step();
    chk("setclr data1", data1, 16'h4545);
    idle();
    step();
    out_ready = 0;
    issue(4'd7, 3'd1, 3'd2, 3'd3, 1);
    step();
    chk("mid out_valid", out_valid, 1);
    in_valid = 0;
    rst_n = 0;
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst ALUSelect", ALUSelect, 0);
    chk("mid rst data1", data1, 0);
    chk("mid rst data2", data2, 0);
    chk("mid rst out_rd", out_rd, 0);
    chk("mid rst out_wr_en", out_wr_en, 0);
    step();
    rst_n = 1;
    idle();
    issue(4'd2, 3'd3, 3'd0, 3'd0, 0);
    #1 chk("mid post ready", in_ready, 1);
    step();
    chk("mid post valid", out_valid, 1);
    chk("mid post data1", data1, 0);
    idle();
    wb(3'd3, 16'h7777);
    step();
    idle();
    issue(4'd2, 3'd3, 3'd0, 3'd0, 0);
    step();
    chk("late wb data1", data1, 16'h7777);
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
